// File: rtl/mipi_rx_lane_deskew.sv
// Lane deskew aligner: finds burst start, measures per-lane skew, re-times all enabled lanes.
// Latency: fixed DEPTH cycles from the first-arriving lane to dout/validout.
// Backpressure: none; the receive path cannot stall, so faults are flagged and the burst dropped.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   lane_en           - enabled-lane mask, captured when a burst starts
//   din, validin      - per-lane bytes from the byte aligners (lane i at [i*WIDTH +: WIDTH])
//   dout, validout    - aligned word; disabled lanes and idle cycles read 0
//   locked            - all enabled lanes aligned and streaming
//   skew              - largest lane offset of the current/last locked burst
//   error, err_code   - one-cycle error pulse; code 1=SKEW 2=DROP 3=GAP, held until next error
//   err_cnt           - saturating error count
module mipi_rx_lane_deskew #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SKW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic [LANES-1:0]       validin,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   validout,
  output logic                   locked,
  output logic [SKW-1:0]         skew,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [7:0]             err_cnt
);

  localparam logic [SKW-1:0] CMAX = SKW'(DEPTH - 1);
  localparam logic [1:0] ERR_SKEW = 2'd1;
  localparam logic [1:0] ERR_DROP = 2'd2;
  localparam logic [1:0] ERR_GAP  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2, RESYNC = 2'd3} state_t;

  state_t state, state_nxt;

  logic [LANES-1:0] en_q;
  logic [LANES-1:0] arr_q;
  logic [SKW-1:0]   off_q [LANES];
  logic [SKW-1:0]   cnt;            // cycles since T0, saturating at DEPTH-1
  logic             from_lock;      // first IDLE cycle after a clean burst end

  // dl[i][j] holds {valid, data} of lane i from j+1 cycles ago.
  logic [WIDTH:0]   dl   [LANES][DEPTH-1];
  logic [WIDTH:0]   taps [LANES][DEPTH];
  logic [SKW-1:0]   tap_sel [LANES];

  logic [LANES-1:0]       dv;
  logic [LANES*WIDTH-1:0] dd;
  logic [LANES-1:0]       new_arr;
  logic all_arr, drop_al, cnt_max, eval, v_all, v_none;
  logic err_set;
  logic [1:0] err_kind;
  logic validout_nxt;
  logic [LANES*WIDTH-1:0] dout_nxt;

  // Tap d gives delay d through the comb path; the output register adds one,
  // so delay d = DEPTH-1-o_i yields DEPTH-o_i in total. A lane arriving in the
  // current ALIGN cycle has no stored offset yet, so it uses cnt directly.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      taps[i][0] = {validin[i], din[i*WIDTH +: WIDTH]};
      for (int j = 1; j < DEPTH; j++) begin
        taps[i][j] = dl[i][j-1];
      end
      tap_sel[i] = CMAX - (arr_q[i] ? off_q[i] : cnt);
      {dv[i], dd[i*WIDTH +: WIDTH]} = taps[i][tap_sel[i]];
    end
  end

  assign new_arr = validin & en_q & ~arr_q;
  assign all_arr = ((arr_q | validin) & en_q) == en_q;
  assign drop_al = |(arr_q & en_q & ~validin);
  assign cnt_max = (cnt == CMAX);
  assign v_all   = (dv & en_q) == en_q;
  assign v_none  = (dv & en_q) == '0;
  // The first aligned word is due at T0+DEPTH; when the last lane arrives at
  // offset DEPTH-1 that evaluation happens while still in ALIGN.
  assign eval    = cnt_max && ((state == LOCKED) ||
                               ((state == ALIGN) && all_arr && !drop_al));
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_kind  = ERR_SKEW;
    unique case (state)
      IDLE: begin
        if (from_lock && |(validin & en_q)) begin
          state_nxt = RESYNC;
          err_set   = 1'b1;
          err_kind  = ERR_GAP;
        end else if (|(validin & lane_en)) begin
          state_nxt = ((validin & lane_en) == lane_en) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        // A drop outranks a simultaneous timeout.
        if (drop_al) begin
          state_nxt = RESYNC;
          err_set   = 1'b1;
          err_kind  = ERR_DROP;
        end else if (all_arr) begin
          state_nxt = LOCKED;
        end else if (cnt_max) begin
          state_nxt = RESYNC;
          err_set   = 1'b1;
          err_kind  = ERR_SKEW;
        end
      end
      LOCKED: begin
        if (cnt_max && !v_all) begin
          if (v_none) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RESYNC;
            err_set   = 1'b1;
            err_kind  = ERR_DROP;
          end
        end
      end
      RESYNC: begin
        if ((validin & en_q) == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    validout_nxt = eval && v_all;
    dout_nxt     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (validout_nxt && en_q[i]) dout_nxt[i*WIDTH +: WIDTH] = dd[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= '0;
      arr_q     <= '0;
      cnt       <= '0;
      from_lock <= 1'b0;
      validout  <= 1'b0;
      dout      <= '0;
      skew      <= '0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= 8'd0;
      for (int i = 0; i < LANES; i++) begin
        off_q[i] <= '0;
        for (int j = 0; j < DEPTH-1; j++) dl[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        dl[i][0] <= {validin[i], din[i*WIDTH +: WIDTH]};
        for (int j = 1; j < DEPTH-1; j++) dl[i][j] <= dl[i][j-1];
      end
      from_lock <= (state == LOCKED) && (state_nxt == IDLE);
      validout  <= validout_nxt;
      dout      <= dout_nxt;
      error     <= err_set;
      if (err_set) begin
        err_code <= err_kind;
        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (state_nxt == ALIGN || state_nxt == LOCKED) begin
            en_q  <= lane_en;
            arr_q <= validin & lane_en;
            cnt   <= SKW'(1);
            for (int i = 0; i < LANES; i++) off_q[i] <= '0;
            if (state_nxt == LOCKED) skew <= '0;
          end
        end
        ALIGN: begin
          if (!cnt_max) cnt <= cnt + 1'b1;
          arr_q <= arr_q | new_arr;
          for (int i = 0; i < LANES; i++) begin
            if (new_arr[i]) off_q[i] <= cnt;
          end
          if (state_nxt == LOCKED) skew <= cnt;
        end
        LOCKED: begin
          if (!cnt_max) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
module tb_mipi_rx_lane_deskew;
  localparam int L = 4;
  localparam int W = 8;
  localparam int D = 4;

  typedef int iarr_t [L];
  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [L-1:0]  lane_en;
  logic [L*W-1:0] din;
  logic [L-1:0]  validin;
  logic [L*W-1:0] dout;
  logic          validout;
  logic          locked;
  logic [1:0]    skew;
  logic          error;
  logic [1:0]    err_code;
  logic [7:0]    err_cnt;

  mipi_rx_lane_deskew #(.LANES(L), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .din(din), .validin(validin),
    .dout(dout), .validout(validout), .locked(locked), .skew(skew),
    .error(error), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   vo_cnt = 0;
  int   err_pulses = 0;
  int   err_exp = 0;
  logic [1:0] last_code = 2'd0;
  logic prev_err = 1'b0;

  // Output monitor: every valid word is popped from the scoreboard and checked
  // for both content and arrival cycle.
  always @(negedge clk) begin
    if (validout === 1'b1) begin
      vo_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_validout cyc=%0d dout=%h", cyc, dout);
      end else begin
        e = sb.pop_front();
        if (dout !== e.dat || cyc != e.cyc) begin
          bad++;
          $display("FAIL out_word got cyc=%0d dout=%h want cyc=%0d dout=%h", cyc, dout, e.cyc, e.dat);
        end
      end
      total++;
      if (locked !== 1'b1) begin
        bad++;
        $display("FAIL locked_with_output cyc=%0d got=%b want=1", cyc, locked);
      end
    end else begin
      total++;
      if (validout !== 1'b0 || dout !== '0) begin
        bad++;
        $display("FAIL idle_output cyc=%0d validout=%b dout=%h want 0/0", cyc, validout, dout);
      end
    end
    if (error === 1'b1) begin
      err_pulses++;
      last_code = err_code;
      total++;
      if (prev_err === 1'b1) begin
        bad++;
        $display("FAIL error_pulse_width cyc=%0d got two-cycle pulse want one", cyc);
      end
    end
    prev_err = error;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] word(input int k, input logic [L-1:0] en);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < L; i++) begin
      if (en[i]) w[i*W +: W] = 8'(16*i + k);
    end
    return w;
  endfunction

  // Drives one burst: enabled lane i is valid for len[i] cycles starting at
  // off[i], carrying byte 16*i+k. Disabled lanes carry random garbage.
  // Expected aligned words are queued as the offset-0 lane's bytes are driven.
  task automatic run_burst(input iarr_t off, input iarr_t len, input logic [L-1:0] en,
                           input bit expect_out, input int rst_at);
    int   span;
    int   minlen;
    bit   v;
    exp_t x;
    span   = 0;
    minlen = 1 << 20;
    for (int i = 0; i < L; i++) begin
      if (en[i]) begin
        if (len[i] < minlen) minlen = len[i];
        if (off[i] + len[i] > span) span = off[i] + len[i];
      end
    end
    lane_en = en;
    for (int t = 0; t < span; t++) begin
      if (t == rst_at) begin
        rst     = 1'b1;
        validin = '0;
        din     = '0;
        step();
        rst = 1'b0;
        return;
      end
      for (int i = 0; i < L; i++) begin
        if (en[i]) begin
          v = (t >= off[i]) && (t < off[i] + len[i]);
          validin[i] = v;
          din[i*W +: W] = v ? 8'(16*i + t - off[i]) : 8'h00;
        end else begin
          validin[i] = 1'($urandom);
          din[i*W +: W] = 8'($urandom);
        end
      end
      if (expect_out && t < minlen && (rst_at < 0 || t + D <= rst_at)) begin
        x.cyc = cyc + D;
        x.dat = word(t, en);
        sb.push_back(x);
      end
      step();
    end
    validin = '0;
    din     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lane_en = '0; validin = '0; din = '0;
    idle(3);
    @(negedge clk);
    total++; if (validout !== 1'b0) begin bad++; $display("FAIL rst_validout got=%b want=0", validout); end
    total++; if (dout !== '0)       begin bad++; $display("FAIL rst_dout got=%h want=0", dout); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
    total++; if (skew !== 2'd0)     begin bad++; $display("FAIL rst_skew got=%0d want=0", skew); end
    total++; if (error !== 1'b0)    begin bad++; $display("FAIL rst_error got=%b want=0", error); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rst_err_code got=%0d want=0", err_code); end
    total++; if (err_cnt !== 8'd0)  begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
    step();
    rst = 1'b0;
  endtask

  task automatic check_after(input string name, input int vo0, input int vo_want, input int e0,
                             input int e_want, input int skew_want);
    total++; if (vo_cnt - vo0 != vo_want) begin bad++; $display("FAIL %s_outputs got=%0d want=%0d", name, vo_cnt - vo0, vo_want); end
    total++; if (err_pulses - e0 != e_want) begin bad++; $display("FAIL %s_errors got=%0d want=%0d", name, err_pulses - e0, e_want); end
    total++; if (err_cnt !== 8'(err_exp)) begin bad++; $display("FAIL %s_err_cnt got=%0d want=%0d", name, err_cnt, err_exp); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL %s_missing_outputs got=%0d left want=0", name, sb.size()); end
    if (skew_want >= 0) begin
      total++; if (skew !== 2'(skew_want)) begin bad++; $display("FAIL %s_skew got=%0d want=%0d", name, skew, skew_want); end
    end
  endtask

  task automatic test_zero_skew();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 0, 0, 0}; len = '{16, 16, 16, 16};
    while (cyc < 10) step();
    vo0 = vo_cnt; e0 = err_pulses;
    run_burst(off, len, 4'b1111, 1'b1, -1);
    idle(D + 6);
    check_after("zero_skew", vo0, 16, e0, 0, 0);
  endtask

  task automatic test_staggered();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 1, 2, 3}; len = '{8, 8, 8, 8};
    vo0 = vo_cnt; e0 = err_pulses;
    run_burst(off, len, 4'b1111, 1'b1, -1);
    idle(D + 6);
    check_after("staggered", vo0, 8, e0, 0, 3);
  endtask

  // Lane 3 arrives one cycle too late and then stays valid alone; leaving
  // RESYNC early would restart alignment and raise a second error.
  task automatic test_skew_error();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 0, 0, 4}; len = '{4, 4, 4, 10};
    vo0 = vo_cnt; e0 = err_pulses;
    err_exp++;
    run_burst(off, len, 4'b1111, 1'b0, -1);
    idle(D + 6);
    check_after("skew_err", vo0, 0, e0, 1, -1);
    total++; if (last_code !== 2'd1) begin bad++; $display("FAIL skew_err_code got=%0d want=1", last_code); end
  endtask

  task automatic test_lane_mask();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 1, 0, 0}; len = '{8, 8, 0, 0};
    vo0 = vo_cnt; e0 = err_pulses;
    run_burst(off, len, 4'b0011, 1'b1, -1);
    idle(D + 6);
    check_after("lane_mask", vo0, 8, e0, 0, 1);
  endtask

  task automatic test_drop();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 0, 0, 0}; len = '{8, 6, 8, 8};
    vo0 = vo_cnt; e0 = err_pulses;
    err_exp++;
    run_burst(off, len, 4'b1111, 1'b1, -1);
    idle(D + 6);
    check_after("drop", vo0, 6, e0, 1, 0);
    total++; if (last_code !== 2'd2) begin bad++; $display("FAIL drop_code got=%0d want=2", last_code); end
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL drop_code_hold got=%0d want=2", err_code); end
  endtask

  task automatic test_gap();
    iarr_t off, len;
    int vo0, e0;
    off = '{0, 0, 0, 0}; len = '{6, 6, 6, 6};
    vo0 = vo_cnt; e0 = err_pulses;
    run_burst(off, len, 4'b1111, 1'b1, -1);
    idle(3);
    err_exp++;
    run_burst(off, len, 4'b1111, 1'b0, -1);
    idle(10);
    run_burst(off, len, 4'b1111, 1'b1, -1);
    idle(D + 6);
    check_after("gap", vo0, 12, e0, 1, 0);
    total++; if (last_code !== 2'd3) begin bad++; $display("FAIL gap_code got=%0d want=3", last_code); end
  endtask

  task automatic test_rst_mid_burst();
    iarr_t off, len;
    int vo0;
    off = '{0, 0, 0, 0}; len = '{10, 10, 10, 10};
    run_burst(off, len, 4'b1111, 1'b1, 6);
    err_exp = 0;
    @(negedge clk);
    total++; if (validout !== 1'b0) begin bad++; $display("FAIL rstmid_validout got=%b want=0", validout); end
    total++; if (dout !== '0)       begin bad++; $display("FAIL rstmid_dout got=%h want=0", dout); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL rstmid_locked got=%b want=0", locked); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rstmid_err_code got=%0d want=0", err_code); end
    total++; if (err_cnt !== 8'd0)  begin bad++; $display("FAIL rstmid_err_cnt got=%0d want=0", err_cnt); end
    vo0 = vo_cnt;
    idle(D + 6);
    total++; if (vo_cnt != vo0) begin bad++; $display("FAIL rstmid_discard got=%0d outputs want=0", vo_cnt - vo0); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rstmid_queue got=%0d left want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    idle(4);
    test_staggered();
    idle(4);
    test_skew_error();
    idle(4);
    test_lane_mask();
    idle(4);
    test_drop();
    idle(4);
    test_gap();
    idle(4);
    test_rst_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
